// File: rtl/addr_decoder.sv
// Mac Plus memory-map decoder: turns the 24-bit CPU byte address and the boot
// overlay flag into registered, mutually exclusive chip selects.
module addr_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] address,
  input  logic        memoryOverlayOn,
  output logic        selectRAM,
  output logic        selectROM,
  output logic        selectSCSI,
  output logic        selectSCC,
  output logic        selectIWM,
  output logic        selectVIA
);

  typedef struct packed {
    logic ram;
    logic rom;
    logic scsi;
    logic scc;
    logic iwm;
    logic via;
  } selects_t;

  selects_t decodeNext;
  selects_t decodeReg;

  always_comb begin
    // NOTE: clearing every select first means no branch can leave one unassigned (no latch).
    decodeNext = '0;
    case (address[23:20])
      4'h0, 4'h1, 4'h2, 4'h3: begin
        // Boot overlay mirrors ROM over low memory until the OS clears it.
        decodeNext.rom = memoryOverlayOn;
        decodeNext.ram = !memoryOverlayOn;
      end
      4'h4:                   decodeNext.rom  = 1'b1;
      4'h5:                   decodeNext.scsi = address[19];
      4'h6:                   decodeNext.ram  = memoryOverlayOn;
      4'h8, 4'h9, 4'hA, 4'hB: decodeNext.scc  = 1'b1;
      4'hC, 4'hD:             decodeNext.iwm  = 1'b1;
      4'hE:                   decodeNext.via  = address[19];
      default:                decodeNext      = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      decodeReg <= '0;
    end else begin
      decodeReg <= decodeNext;
    end
  end

  assign selectRAM  = decodeReg.ram;
  assign selectROM  = decodeReg.rom;
  assign selectSCSI = decodeReg.scsi;
  assign selectSCC  = decodeReg.scc;
  assign selectIWM  = decodeReg.iwm;
  assign selectVIA  = decodeReg.via;

endmodule

// File: tb/tb_addr_decoder.sv
// Self-checking bench for addr_decoder: range-based reference model checked every
// cycle, plus directed vectors with hand-computed selects.
module tb_addr_decoder;

  localparam logic [5:0] SEL_NONE = 6'b000000;
  localparam logic [5:0] SEL_RAM  = 6'b100000;
  localparam logic [5:0] SEL_ROM  = 6'b010000;
  localparam logic [5:0] SEL_SCSI = 6'b001000;
  localparam logic [5:0] SEL_SCC  = 6'b000100;
  localparam logic [5:0] SEL_IWM  = 6'b000010;
  localparam logic [5:0] SEL_VIA  = 6'b000001;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] address;
  logic        memoryOverlayOn;
  logic        selectRAM, selectROM, selectSCSI, selectSCC, selectIWM, selectVIA;
  logic [5:0]  dutSel;

  int vectorCount = 0;
  int missCount   = 0;

  addr_decoder dut (
    .clk             (clk),
    .reset           (reset),
    .address         (address),
    .memoryOverlayOn (memoryOverlayOn),
    .selectRAM       (selectRAM),
    .selectROM       (selectROM),
    .selectSCSI      (selectSCSI),
    .selectSCC       (selectSCC),
    .selectIWM       (selectIWM),
    .selectVIA       (selectVIA)
  );

  always #5 clk = ~clk;

  assign dutSel = {selectRAM, selectROM, selectSCSI, selectSCC, selectIWM, selectVIA};

  // Memory map expressed as plain numeric address ranges.
  function automatic logic [5:0] refDecode(input logic [23:0] a, input logic ov);
    int unsigned v;
    v = a;
    if (v <= 'h3FFFFF) return ov ? SEL_ROM : SEL_RAM;
    if (v <= 'h4FFFFF) return SEL_ROM;
    if (v >= 'h580000 && v <= 'h5FFFFF) return SEL_SCSI;
    if (v >= 'h600000 && v <= 'h6FFFFF) return ov ? SEL_RAM : SEL_NONE;
    if (v >= 'h800000 && v <= 'hBFFFFF) return SEL_SCC;
    if (v >= 'hC00000 && v <= 'hDFFFFF) return SEL_IWM;
    if (v >= 'hE80000 && v <= 'hEFFFFF) return SEL_VIA;
    return SEL_NONE;
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL %s: got %b expected %b (addr=%h ov=%b t=%0t)",
               name, act, exp, address, memoryOverlayOn, $time);
    end
  endtask

  // Every cycle: outputs must equal the decode of the inputs seen at this edge.
  always @(posedge clk) begin
    logic [5:0] expSel;
    expSel = reset ? SEL_NONE : refDecode(address, memoryOverlayOn);
    #1;
    check("cycle", dutSel, expSel);
    check("exclusive", {5'b0, ($countones(dutSel) > 1)}, 6'b0);
  end

  task automatic applyVec(input logic [23:0] a, input logic ov, input logic rst);
    @(negedge clk);
    address         = a;
    memoryOverlayOn = ov;
    reset           = rst;
  endtask

  task automatic directed(input string name, input logic [23:0] a, input logic ov,
                          input logic [5:0] exp);
    applyVec(a, ov, 1'b0);
    @(posedge clk);
    #2;
    check(name, dutSel, exp);
    check({name, "_model"}, refDecode(a, ov), exp);
  endtask

  initial begin
    reset           = 1'b1;
    address         = 24'h000000;
    memoryOverlayOn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset", dutSel, SEL_NONE);

    directed("release",     24'h000000, 1'b0, SEL_RAM);
    directed("ovl_rom",     24'h000100, 1'b1, SEL_ROM);
    directed("ovl_ram",     24'h000100, 1'b0, SEL_RAM);
    directed("ram_top",     24'h3FFFFF, 1'b0, SEL_RAM);
    directed("hi_ram_ovl",  24'h600000, 1'b1, SEL_RAM);
    directed("hi_ram_none", 24'h600000, 1'b0, SEL_NONE);
    directed("rom_lo",      24'h400000, 1'b0, SEL_ROM);
    directed("rom_hi",      24'h4FFFFF, 1'b1, SEL_ROM);
    directed("gap_57",      24'h57FFFF, 1'b0, SEL_NONE);
    directed("scsi_lo",     24'h580000, 1'b0, SEL_SCSI);
    directed("scsi_hi",     24'h5FFFFF, 1'b0, SEL_SCSI);
    directed("gap_7x",      24'h7ABCDE, 1'b1, SEL_NONE);
    directed("scc_rd",      24'h9FFFF8, 1'b0, SEL_SCC);
    directed("scc_wr",      24'hBFFFF9, 1'b0, SEL_SCC);
    directed("iwm",         24'hDFE1FF, 1'b0, SEL_IWM);
    directed("via",         24'hEFE1FE, 1'b0, SEL_VIA);
    directed("gap_e7",      24'hE7FFFF, 1'b0, SEL_NONE);
    directed("gap_f0",      24'hF00000, 1'b0, SEL_NONE);

    // Reset must win over a decodable address.
    applyVec(24'h400000, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    check("reset_prio", dutSel, SEL_NONE);

    for (int i = 0; i < 10000; i++) begin
      applyVec(24'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
    end
    @(posedge clk);
    #3;

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
